// File: rtl/lsu_if.sv
// Memory-side bus of the LSU: request/grant handshake followed by a response-valid beat.
// master = LSU, slave = memory or interconnect.
interface lsu_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu.sv
// RV32I load/store unit: IDLE->REQ->WAIT->DONE, done 3 cycles after start at best; REQ holds until mem_gnt.
// WAIT bounded by TIMEOUT_CYCLES; define LSU_MISALIGN_TRAP_EN to trap misaligned halfword/word accesses.
module lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misalign_err,
  output logic        bus_err,
  lsu_if.master       mem
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] rdata_q, rdata_d;
  logic        misalign_q, misalign_d;
  logic        bus_err_q, bus_err_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        is_store_q, is_store_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        legal;
  logic        trap;
  logic [31:0] st_data;
  logic [3:0]  st_strb;
  logic [31:0] shifted;
  logic [15:0] half_sel;
  logic [31:0] ld_data;

  // Decode of the request presented in IDLE.
  always_comb begin
    legal = is_store ? (funct3 inside {3'b000, 3'b001, 3'b010})
                     : (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
`ifdef LSU_MISALIGN_TRAP_EN
    trap = legal && (((funct3[1:0] == 2'b01) && addr[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00)));
`else
    trap = 1'b0;
`endif
    case (funct3[1:0])
      2'b00:   begin st_data = {4{wdata[7:0]}};  st_strb = 4'b0001 << addr[1:0]; end
      2'b01:   begin st_data = {2{wdata[15:0]}}; st_strb = addr[1] ? 4'b1100 : 4'b0011; end
      default: begin st_data = wdata;            st_strb = 4'b1111; end
    endcase
  end

  // Lane select and extension of the returning load word.
  always_comb begin
    shifted  = mem.mem_rdata >> {addr_lo_q, 3'b000};
    half_sel = addr_lo_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
    case (funct3_q)
      3'b000:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ld_data = {{16{half_sel[15]}}, half_sel};
      3'b100:  ld_data = {24'h0, shifted[7:0]};
      3'b101:  ld_data = {16'h0, half_sel};
      default: ld_data = mem.mem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    rdata_d     = rdata_q;
    misalign_d  = misalign_q;
    bus_err_d   = bus_err_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    funct3_d    = funct3_q;
    is_store_d  = is_store_q;
    addr_lo_d   = addr_lo_q;
    cnt_d       = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d     = 1'b1;
          funct3_d   = funct3;
          is_store_d = is_store;
          addr_lo_d  = addr[1:0];
          if (!legal) begin
            state_d    = S_DONE;
            done_d     = 1'b1;
            rdata_d    = 32'h0;
            misalign_d = 1'b0;
            bus_err_d  = 1'b0;
          end else if (trap) begin
            state_d    = S_DONE;
            done_d     = 1'b1;
            misalign_d = 1'b1;
            bus_err_d  = 1'b0;
          end else begin
            state_d     = S_REQ;
            mem_req_d   = 1'b1;
            mem_we_d    = is_store;
            mem_addr_d  = {addr[31:2], 2'b00};
            mem_wdata_d = is_store ? st_data : 32'h0;
            mem_wstrb_d = is_store ? st_strb : 4'b0000;
          end
        end
      end
      S_REQ: begin
        if (mem.mem_gnt) begin
          state_d   = S_WAIT;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          cnt_d     = 8'h0;
        end
      end
      S_WAIT: begin
        if (mem.mem_rvalid) begin
          state_d    = S_DONE;
          done_d     = 1'b1;
          misalign_d = 1'b0;
          bus_err_d  = 1'b0;
          if (!is_store_q) rdata_d = ld_data;
        end else if (cnt_q == TO_LAST) begin
          state_d    = S_DONE;
          done_d     = 1'b1;
          misalign_d = 1'b0;
          bus_err_d  = 1'b1;
          rdata_d    = 32'h0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rdata_q     <= 32'h0;
      misalign_q  <= 1'b0;
      bus_err_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_wstrb_q <= 4'h0;
      funct3_q    <= 3'h0;
      is_store_q  <= 1'b0;
      addr_lo_q   <= 2'h0;
      cnt_q       <= 8'h0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      misalign_q  <= misalign_d;
      bus_err_q   <= bus_err_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      funct3_q    <= funct3_d;
      is_store_q  <= is_store_d;
      addr_lo_q   <= addr_lo_d;
      cnt_q       <= cnt_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign rdata         = rdata_q;
  assign misalign_err  = misalign_q;
  assign bus_err       = bus_err_q;
  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign mem.mem_wstrb = mem_wstrb_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with TIMEOUT_CYCLES=8; cycle 0 is the cycle in which start is driven.
module tb_lsu;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        busy, done, misalign_err, bus_err;
  logic [31:0] rdata;
  int          total = 0;
  int          bad = 0;

  lsu_if bus ();

  always #5 clk = ~clk;

  lsu #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store), .funct3(funct3),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
    .misalign_err(misalign_err), .bus_err(bus_err), .mem(bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Presents one request for a single cycle; returns in cycle 1.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    is_store = st; funct3 = f3; addr = a; wdata = wd; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
    rst_n = 1'b0;
    tick(); tick();
    total++;
    if ({busy, done, misalign_err, bus_err, bus.mem_req, bus.mem_we} !== 6'b0) begin
      bad++; $display("FAIL reset_flags got=%b exp=000000", {busy, done, misalign_err, bus_err, bus.mem_req, bus.mem_we});
    end
    total++;
    if ({rdata, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb} !== 100'h0) begin
      bad++; $display("FAIL reset_data got rdata=%h addr=%h wdata=%h wstrb=%b", rdata, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_lb;
    bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h80FF_FF7F;
    issue(1'b0, 3'b000, 32'h0000_1003, 32'h0);
    total++;
    if ({busy, done, bus.mem_req, bus.mem_we, bus.mem_wstrb} !== 8'b1010_0000 || bus.mem_addr !== 32'h1000) begin
      bad++; $display("FAIL lb_req got flags=%b addr=%h exp flags=10100000 addr=00001000",
                      {busy, done, bus.mem_req, bus.mem_we, bus.mem_wstrb}, bus.mem_addr);
    end
    start = 1'b1; addr = 32'h5000;
    tick();
    total++;
    if ({busy, done, bus.mem_req} !== 3'b100) begin
      bad++; $display("FAIL lb_wait got=%b exp=100", {busy, done, bus.mem_req});
    end
    tick();
    start = 1'b0;
    total++;
    if ({done, bus_err, misalign_err} !== 3'b100 || rdata !== 32'hFFFF_FF80) begin
      bad++; $display("FAIL lb_done got flags=%b rdata=%h exp flags=100 rdata=ffffff80", {done, bus_err, misalign_err}, rdata);
    end
    tick(); tick();
    total++;
    if ({busy, done, bus.mem_req} !== 3'b000) begin
      bad++; $display("FAIL lb_busy_start_ignored got=%b exp=000", {busy, done, bus.mem_req});
    end
  endtask

  task automatic test_store;
    logic [2:0]  f3_t [3] = '{3'b001, 3'b000, 3'b010};
    logic [31:0] a_t  [3] = '{32'h0000_2002, 32'h0000_2001, 32'h0000_2004};
    logic [31:0] wd_t [3] = '{32'h1234_ABCD, 32'h0000_005A, 32'hCAFE_F00D};
    logic [31:0] ea_t [3] = '{32'h0000_2000, 32'h0000_2000, 32'h0000_2004};
    logic [31:0] ed_t [3] = '{32'hABCD_ABCD, 32'h5A5A_5A5A, 32'hCAFE_F00D};
    logic [3:0]  es_t [3] = '{4'b1100, 4'b0010, 4'b1111};
    bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h7777_7777;
    for (int i = 0; i < 3; i++) begin
      issue(1'b1, f3_t[i], a_t[i], wd_t[i]);
      total++;
      if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== ea_t[i] ||
          bus.mem_wdata !== ed_t[i] || bus.mem_wstrb !== es_t[i]) begin
        bad++; $display("FAIL store_bus[%0d] got req=%b we=%b addr=%h wdata=%h wstrb=%b exp addr=%h wdata=%h wstrb=%b",
                        i, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb, ea_t[i], ed_t[i], es_t[i]);
      end
      tick(); tick();
      total++;
      if (done !== 1'b1 || rdata !== 32'hFFFF_FF80) begin
        bad++; $display("FAIL store_done[%0d] got done=%b rdata=%h exp done=1 rdata=ffffff80", i, done, rdata);
      end
      tick();
    end
  endtask

  task automatic test_load_ext;
    logic [2:0]  f3_t [5] = '{3'b001, 3'b100, 3'b000, 3'b101, 3'b010};
    logic [31:0] a_t  [5] = '{32'h0000_0002, 32'h0000_0001, 32'h0000_0000, 32'h0000_0002, 32'h0000_0008};
    logic [31:0] rd_t [5] = '{32'h8001_1234, 32'h0000_F000, 32'h0000_0012, 32'hFFFF_0000, 32'h1357_9BDF};
    logic [31:0] ex_t [5] = '{32'hFFFF_8001, 32'h0000_00F0, 32'h0000_0012, 32'h0000_FFFF, 32'h1357_9BDF};
    bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.mem_rdata = rd_t[i];
      issue(1'b0, f3_t[i], a_t[i], 32'h0);
      tick(); tick();
      total++;
      if (done !== 1'b1 || rdata !== ex_t[i]) begin
        bad++; $display("FAIL load_ext[%0d] got done=%b rdata=%h exp done=1 rdata=%h", i, done, rdata, ex_t[i]);
      end
      tick();
    end
  endtask

  task automatic test_timeout;
    bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h1111_1111;
    issue(1'b0, 3'b010, 32'h0000_3000, 32'h0);
    tick();
    repeat (7) tick();
    total++;
    if ({busy, done} !== 2'b10) begin
      bad++; $display("FAIL timeout_early got busy,done=%b exp=10", {busy, done});
    end
    tick();
    total++;
    if ({done, bus_err} !== 2'b11 || rdata !== 32'h0) begin
      bad++; $display("FAIL timeout_done got done,bus_err=%b rdata=%h exp=11 rdata=00000000", {done, bus_err}, rdata);
    end
    tick();
  endtask

  task automatic test_illegal(input logic st, input logic [2:0] f3);
    bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'b1;
    issue(st, f3, 32'h0000_0040, 32'hFFFF_FFFF);
    total++;
    if ({busy, done, bus.mem_req, misalign_err, bus_err} !== 5'b11000 || rdata !== 32'h0) begin
      bad++; $display("FAIL illegal_f3_%b got flags=%b rdata=%h exp flags=11000 rdata=00000000",
                      f3, {busy, done, bus.mem_req, misalign_err, bus_err}, rdata);
    end
    tick();
    total++;
    if ({busy, done, bus.mem_req} !== 3'b000) begin
      bad++; $display("FAIL illegal_idle_%b got=%b exp=000", f3, {busy, done, bus.mem_req});
    end
  endtask

  task automatic test_gnt_stall;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEAD_8765;
    issue(1'b0, 3'b101, 32'h0000_0000, 32'h0);
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({busy, done, bus.mem_req, bus.mem_we, bus.mem_wstrb} !== 8'b1010_0000 || bus.mem_addr !== 32'h0) begin
        bad++; $display("FAIL stall_hold[%0d] got flags=%b addr=%h exp flags=10100000 addr=00000000",
                        i, {busy, done, bus.mem_req, bus.mem_we, bus.mem_wstrb}, bus.mem_addr);
      end
      tick();
    end
    bus.mem_gnt = 1'b1;
    total++;
    if (bus.mem_req !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL stall_fifth got req=%b done=%b exp req=1 done=0", bus.mem_req, done);
    end
    tick();
    total++;
    if ({bus.mem_req, done} !== 2'b00) begin
      bad++; $display("FAIL stall_wait got req,done=%b exp=00", {bus.mem_req, done});
    end
    tick();
    total++;
    if (done !== 1'b1 || rdata !== 32'h0000_8765) begin
      bad++; $display("FAIL stall_done got done=%b rdata=%h exp done=1 rdata=00008765", done, rdata);
    end
    tick();
  endtask

  task automatic test_misalign;
    bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1122_3344;
    issue(1'b0, 3'b010, 32'h0000_1002, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    total++;
    if ({busy, done, bus.mem_req, misalign_err} !== 4'b1101 || rdata !== 32'h0000_8765) begin
      bad++; $display("FAIL misalign_trap got flags=%b rdata=%h exp flags=1101 rdata=00008765",
                      {busy, done, bus.mem_req, misalign_err}, rdata);
    end
    tick();
`else
    total++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h1000) begin
      bad++; $display("FAIL misalign_req got req=%b addr=%h exp req=1 addr=00001000", bus.mem_req, bus.mem_addr);
    end
    tick(); tick();
    total++;
    if ({done, misalign_err} !== 2'b10 || rdata !== 32'h1122_3344) begin
      bad++; $display("FAIL misalign_load got done,err=%b rdata=%h exp=10 rdata=11223344", {done, misalign_err}, rdata);
    end
    tick();
`endif
  endtask

  task automatic test_reset_mid;
    bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h55AA_55AA;
    issue(1'b0, 3'b010, 32'h0000_4000, 32'h0);
    tick(); tick();
    bus.mem_rvalid = 1'b0;
    issue(1'b1, 3'b010, 32'h0000_4004, 32'h9999_9999);
    tick();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, misalign_err, bus_err, bus.mem_req, bus.mem_we} !== 6'b0 ||
        {rdata, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb} !== 100'h0) begin
      bad++; $display("FAIL reset_mid got flags=%b rdata=%h addr=%h wdata=%h wstrb=%b exp all zero",
                      {busy, done, misalign_err, bus_err, bus.mem_req, bus.mem_we},
                      rdata, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb);
    end
    tick();
    rst_n = 1'b1;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0BAD_F00D;
    issue(1'b0, 3'b010, 32'h0000_4008, 32'h0);
    total++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h4008) begin
      bad++; $display("FAIL after_reset_req got req=%b addr=%h exp req=1 addr=00004008", bus.mem_req, bus.mem_addr);
    end
    tick(); tick();
    total++;
    if (done !== 1'b1 || rdata !== 32'h0BAD_F00D) begin
      bad++; $display("FAIL after_reset_done got done=%b rdata=%h exp done=1 rdata=0badf00d", done, rdata);
    end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lb();
    test_store();
    test_load_ext();
    test_timeout();
    test_illegal(1'b1, 3'b100);
    test_gnt_stall();
    test_misalign();
    test_illegal(1'b0, 3'b011);
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL set the maximum cycles spent in WAIT before a bus error; legal range 1..255.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 start  input  1  SHALL be the access request from execute, sampled only in IDLE.
REQ-005 is_store  input  1  SHALL select store (1) or load (0).
REQ-006 funct3  input  3  SHALL be the RV32I load/store width code.
REQ-007 addr  input  32  SHALL be the effective address, taken from the ALU result.
REQ-008 wdata  input  32  SHALL be the store data (rs2).
REQ-009 busy  output  1  SHALL be high in every state except IDLE.
REQ-010 done  output  1  SHALL be a one-cycle completion pulse.
REQ-011 rdata  output  32  SHALL be the extended load result, registered, valid with done, held until the next done.
REQ-012 misalign_err  output  1  SHALL flag a misaligned access, valid with done.
REQ-013 bus_err  output  1  SHALL flag a response timeout, valid with done.
REQ-014 mem_req / mem_we  output  1 / 1  SHALL be the bus request and write-enable.
REQ-015 mem_addr / mem_wdata / mem_wstrb  output  32 / 32 / 4  SHALL be the word-aligned address ({addr[31:2],2'b00}), lane-replicated data and byte strobes.
REQ-016 mem_gnt / mem_rvalid / mem_rdata  input  1 / 1 / 32  SHALL be the bus grant, response valid (load data or store ack) and response data.

Function
REQ-017 FSM states SHALL be IDLE, REQ, WAIT and DONE.
REQ-018 IDLE SHALL capture addr, wdata, funct3 and is_store on start and move to REQ; a start while busy SHALL be ignored.
REQ-019 REQ SHALL hold mem_req=1 and all bus outputs stable until mem_gnt=1, then move to WAIT.
REQ-020 WAIT SHALL ignore mem_rvalid in the grant cycle, accept it only in WAIT, then move to DONE; DONE SHALL assert done for one cycle and return to IDLE.
REQ-021 Minimum latency: start at cycle 0, mem_req at cycle 1 with gnt, rvalid at cycle 2, done at cycle 3.
REQ-022 Loads SHALL decode as LB 000, LH 001, LW 010, LBU 100, LHU 101; stores SHALL decode as SB 000, SH 001, SW 010.
REQ-023 Loads SHALL select the byte at addr[1:0] or the halfword at addr[1], sign-extended for LB/LH and zero-extended for LBU/LHU.
REQ-024 SB SHALL replicate wdata[7:0] to all four lanes with wstrb = 4'b0001 << addr[1:0].
REQ-025 SH SHALL replicate wdata[15:0] with wstrb 0011 (addr[1]=0) or 1100 (addr[1]=1).
REQ-026 SW SHALL use wstrb 1111.
REQ-027 Loads SHALL drive wstrb 0000 and mem_we 0.
REQ-028 An illegal funct3 SHALL go IDLE->DONE with no mem_req, rdata=0 and both error flags 0.
REQ-029 A WAIT timeout counter SHALL clear on entry to WAIT; when it reaches TIMEOUT_CYCLES without rvalid, the FSM SHALL go to DONE with bus_err=1 and rdata=0.
REQ-030 Store completion SHALL leave rdata unchanged.

Reset
REQ-031 rst_n low SHALL force IDLE immediately, including mid-access, and clear busy, done, rdata, misalign_err, bus_err, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb and the timeout counter to 0.
REQ-032 After reset the first start SHALL be accepted normally.

Configuration
REQ-033 With macro LSU_MISALIGN_TRAP_EN defined, a halfword access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL go IDLE->DONE with no mem_req, misalign_err=1 and rdata unchanged.
REQ-034 Without LSU_MISALIGN_TRAP_EN, misaligned accesses SHALL proceed with offending low address bits treated as zero, and misalign_err SHALL be tied to 0.

Verification
REQ-035 LB addr=0x1003, mem_rdata=0x80FF_FF7F, gnt and rvalid immediate -> mem_addr=0x1000, done at cycle 3, rdata=0xFFFF_FF80.
REQ-036 SH addr=0x2002, wdata=0x1234_ABCD -> mem_we=1, mem_wdata=0xABCD_ABCD, wstrb=1100, done after ack.
REQ-037 LHU addr=0x0, gnt held low 4 cycles -> mem_req and bus outputs stable for 5 cycles; rdata = zero-extended mem_rdata[15:0].
REQ-038 LW, rvalid never returns, TIMEOUT_CYCLES=8 -> done after 8 WAIT cycles with bus_err=1 and rdata=0.
REQ-039 LW addr=0x1002 -> with LSU_MISALIGN_TRAP_EN: no mem_req, done at cycle 1, misalign_err=1; without it: mem_addr=0x1000 and a normal load.
REQ-040 rst_n low during WAIT, then start -> immediate IDLE with outputs 0; the new access completes normally.
